// File: rtl/wired_bitscan_pkg.sv
// Shared types and helpers for the wired_bitscan_iter set-bit iterator.
package wired_bitscan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_e;

   // Widest mask bitrev can reverse; callers zero-extend into this width.
   localparam int BITREV_MAX_W = 1024;

   // Reverses the low w bits of mask into the low w bits of the result.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] mask,
                                                      input int w);
      logic [BITREV_MAX_W-1:0] r;
      r = {<<{mask}};
      return r >> (BITREV_MAX_W - w);
   endfunction

   function automatic int popcnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/wired_bitscan_lane.sv
// Combinational find-first-set lane: lowest set bit index plus the mask with that bit removed.
module wired_bitscan_lane #(
   parameter int WIDTH = 16,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] mask,
   output logic             found,
   output logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] cleared_mask
);

   localparam int PAD = 1 << IDX_W;

   // Balanced tree: leaves are padded to a power of two, lower half wins each merge.
   for (genvar l = 0; l <= IDX_W; l++) begin : lvl
      localparam int N = PAD >> l;
      logic [N-1:0]            f;
      logic [N-1:0][IDX_W-1:0] ix;
      if (l == 0) begin : g_leaf
         for (genvar n = 0; n < N; n++) begin : g_bit
            if (n < WIDTH) begin : g_real
               assign f[n] = mask[n];
            end else begin : g_pad
               assign f[n] = 1'b0;
            end
            assign ix[n] = IDX_W'(n);
         end
      end else begin : g_node
         for (genvar n = 0; n < N; n++) begin : g_merge
            assign f[n]  = lvl[l-1].f[2*n] | lvl[l-1].f[2*n+1];
            assign ix[n] = lvl[l-1].f[2*n] ? lvl[l-1].ix[2*n] : lvl[l-1].ix[2*n+1];
         end
      end
   end

   logic [WIDTH-1:0] sel;

   assign found        = lvl[IDX_W].f[0];
   assign idx          = found ? lvl[IDX_W].ix[0] : '0;
   assign sel          = found ? (WIDTH'(1) << idx) : '0;
   assign cleared_mask = mask & ~sel;

endmodule

// File: rtl/wired_bitscan_iter.sv
// Sequential set-bit iterator emitting up to LANES indices per beat, LSB- or MSB-first.
// Optional remaining-count and first-beat outputs are enabled by WIRED_BITSCAN_POPCNT_EN.
module wired_bitscan_iter
   import wired_bitscan_pkg::*;
#(
   parameter int   WIDTH = 16,
   parameter int   LANES = 2,
   parameter logic MODE  = 1'b0,
   parameter int   TAG_W = 4,
   parameter int   IDX_W = $clog2(WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [WIDTH-1:0]       in_mask_i,
   input  logic [TAG_W-1:0]       in_tag_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [LANES*IDX_W-1:0] out_idx_o,
   output logic [LANES-1:0]       out_lane_vld_o,
   output logic                   out_last_o,
`ifdef WIRED_BITSCAN_POPCNT_EN
   output logic [popcnt_w(WIDTH)-1:0] out_remain_o,
   output logic                   out_first_o,
`endif
   output logic [TAG_W-1:0]       out_tag_o
);

   scan_state_e      state_q;
   logic [WIDTH-1:0] rem_q;
   logic [TAG_W-1:0] tag_q;
   logic [WIDTH-1:0] load_mask;
   logic [WIDTH-1:0] rest;
   logic             out_fire;
   logic             accept;

   // rem_q is always held in scan order, so MSB-first mode reverses once at load.
   if (MODE) begin : g_rev
      logic [BITREV_MAX_W-1:0] ext;
      always_comb begin
         ext              = '0;
         ext[WIDTH-1:0]   = in_mask_i;
      end
      assign load_mask = WIDTH'(bitrev(ext, WIDTH));
   end else begin : g_fwd
      assign load_mask = in_mask_i;
   end

   for (genvar k = 0; k < LANES; k++) begin : ln
      logic [WIDTH-1:0] m_in;
      logic [WIDTH-1:0] m_out;
      logic             found;
      logic [IDX_W-1:0] raw;
      if (k == 0) begin : g_head
         assign m_in = rem_q;
      end else begin : g_tail
         assign m_in = ln[k-1].m_out;
      end
      wired_bitscan_lane #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lane (
         .mask         (m_in),
         .found        (found),
         .idx          (raw),
         .cleared_mask (m_out)
      );
      assign out_lane_vld_o[k] = found;
      if (MODE) begin : g_msb
         assign out_idx_o[k*IDX_W +: IDX_W] = found ? (IDX_W'(WIDTH - 1) - raw) : '0;
      end else begin : g_lsb
         assign out_idx_o[k*IDX_W +: IDX_W] = raw;
      end
   end

   assign rest        = ln[LANES-1].m_out;
   assign out_valid_o = (state_q == SCAN);
   assign out_last_o  = out_valid_o && (rest == '0);
   assign out_tag_o   = tag_q;
   assign out_fire    = out_valid_o && out_ready_i;
   assign in_ready_o  = !flush_i && ((state_q == IDLE) || (out_fire && out_last_o));
   assign accept      = in_valid_i && in_ready_o;

   // Flush wins over everything; a new request replaces a finishing one without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         tag_q   <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else if (accept) begin
         state_q <= SCAN;
         rem_q   <= load_mask;
         tag_q   <= in_tag_i;
      end else if (out_fire) begin
         if (out_last_o) begin
            state_q <= IDLE;
            rem_q   <= '0;
         end else begin
            rem_q   <= rest;
         end
      end
   end

`ifdef WIRED_BITSCAN_POPCNT_EN
   localparam int CNT_W = popcnt_w(WIDTH);
   logic first_q;

   always_comb begin
      out_remain_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         out_remain_o = out_remain_o + CNT_W'(rem_q[i]);
      end
   end

   assign out_first_o = first_q && out_valid_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b0;
      end else if (flush_i) begin
         first_q <= 1'b0;
      end else if (accept) begin
         first_q <= 1'b1;
      end else if (out_fire) begin
         first_q <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_wired_bitscan_iter.sv
// Bench for wired_bitscan_iter: LSB-first and MSB-first instances share stimulus, checked against a beat scoreboard.
module tb_wired_bitscan_iter;

   localparam int WIDTH = 8;
   localparam int LANES = 2;
   localparam int TAG_W = 4;
   localparam int IDX_W = 3;

   typedef struct packed {
      logic [2:0] i1;
      logic [2:0] i0;
      logic [1:0] vld;
      logic       last;
      logic [3:0] tag;
   } beat_t;

   typedef struct {
      logic [7:0] mask;
      logic [3:0] tag;
      int         beats;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_mask;
   logic [TAG_W-1:0] in_tag;
   logic             out_ready;

   logic                   in_ready0, out_valid0, last0;
   logic [LANES*IDX_W-1:0] out_idx0;
   logic [LANES-1:0]       vld0;
   logic [TAG_W-1:0]       tag0;
   logic                   in_ready1, out_valid1, last1;
   logic [LANES*IDX_W-1:0] out_idx1;
   logic [LANES-1:0]       vld1;
   logic [TAG_W-1:0]       tag1;

   beat_t q0[$];
   beat_t q1[$];
   int    checks;
   int    errors;
   int    beat_cnt[2];
   vec_t  vecs[6];

   wired_bitscan_iter #(.WIDTH(WIDTH), .LANES(LANES), .MODE(1'b0), .TAG_W(TAG_W)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready0), .in_mask_i(in_mask), .in_tag_i(in_tag),
      .out_valid_o(out_valid0), .out_ready_i(out_ready), .out_idx_o(out_idx0),
      .out_lane_vld_o(vld0), .out_last_o(last0), .out_tag_o(tag0)
   );

   wired_bitscan_iter #(.WIDTH(WIDTH), .LANES(LANES), .MODE(1'b1), .TAG_W(TAG_W)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready1), .in_mask_i(in_mask), .in_tag_i(in_tag),
      .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_idx_o(out_idx1),
      .out_lane_vld_o(vld1), .out_last_o(last1), .out_tag_o(tag1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] simulation did not terminate");
   end

   // Reference model: list set bits in scan order and pack them LANES at a time.
   task automatic pushBeats(input int m, input logic [7:0] mask, input logic [3:0] tag);
      int         list[$];
      beat_t      b;
      logic [2:0] p;
      for (int i = 0; i < 8; i++) begin
         p = (m == 0) ? 3'(i) : 3'(7 - i);
         if (mask[p]) list.push_back(int'(p));
      end
      if (list.size() == 0) begin
         b      = '0;
         b.last = 1'b1;
         b.tag  = tag;
         if (m == 0) q0.push_back(b); else q1.push_back(b);
      end
      for (int j = 0; j < list.size(); j += 2) begin
         b        = '0;
         b.tag    = tag;
         b.i0     = 3'(list[j]);
         b.vld[0] = 1'b1;
         if (j + 1 < list.size()) begin
            b.i1     = 3'(list[j+1]);
            b.vld[1] = 1'b1;
         end
         b.last = (j + 2 >= list.size());
         if (m == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   task automatic checkDut(input int m, input logic ov, input logic ir, input beat_t got);
      beat_t exp;
      if (ov) begin
         checks++;
         if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            errors++;
            $display("[TB] FAIL beat_unexpected mode%0d got=%h required=none", m, got);
         end else begin
            exp = (m == 0) ? q0[0] : q1[0];
            if (got !== exp) begin
               errors++;
               $display("[TB] FAIL beat mode%0d got=%h required=%h", m, got, exp);
            end
            if (out_ready && !flush) begin
               if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
               beat_cnt[m]++;
            end
         end
      end
      if (ir && in_valid) pushBeats(m, in_mask, in_tag);
   endtask

   task automatic checkOutput();
      checkDut(0, out_valid0, in_ready0, beat_t'({out_idx0[5:3], out_idx0[2:0], vld0, last0, tag0}));
      checkDut(1, out_valid1, in_ready1, beat_t'({out_idx1[5:3], out_idx1[2:0], vld1, last1, tag1}));
      if (flush) begin
         q0.delete();
         q1.delete();
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] m, input logic [3:0] t,
                                input logic r, input logic f);
      @(negedge clk);
      in_valid  = v;
      in_mask   = m;
      in_tag    = t;
      out_ready = r;
      flush     = f;
      #1;
      checkOutput();
   endtask

   task automatic expectBit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%b required=%b", name, got, exp);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 16; i++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         applyStimulus(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      end
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout pending=%0d/%0d required=0/0", q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
   endtask

   initial begin
      vecs[0] = '{8'b1011_0010, 4'h1, 2};
      vecs[1] = '{8'h00,        4'h3, 1};
      vecs[2] = '{8'hFF,        4'h5, 4};
      vecs[3] = '{8'h01,        4'h2, 1};
      vecs[4] = '{8'h80,        4'h7, 1};
      vecs[5] = '{8'b0101_0100, 4'h9, 2};

      clk = 1'b0;
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_mask = '0;
      in_tag = '0;
      out_ready = 1'b0;
      checks = 0;
      errors = 0;
      beat_cnt = '{0, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      expectBit("reset_valid0", out_valid0, 1'b0);
      expectBit("reset_ready0", in_ready0, 1'b1);
      expectBit("reset_valid1", out_valid1, 1'b0);
      expectBit("reset_ready1", in_ready1, 1'b1);
      checks++;
      if ({out_idx0, vld0, last0, tag0, out_idx1, vld1, last1, tag1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got=%h required=0",
                  {out_idx0, vld0, last0, tag0, out_idx1, vld1, last1, tag1});
      end

      for (int v = 0; v < 6; v++) begin
         beat_cnt = '{0, 0};
         applyStimulus(1'b1, vecs[v].mask, vecs[v].tag, 1'b1, 1'b0);
         applyStimulus(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
         expectBit("latency0", out_valid0, 1'b1);
         expectBit("latency1", out_valid1, 1'b1);
         drain();
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (beat_cnt[m] != vecs[v].beats) begin
               errors++;
               $display("[TB] FAIL beat_count vec%0d mode%0d got=%0d required=%0d",
                        v, m, beat_cnt[m], vecs[v].beats);
            end
         end
      end

      // Back-to-back: second request accepted on the last beat of the first.
      applyStimulus(1'b1, 8'b0000_0100, 4'h1, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'b1000_0000, 4'h2, 1'b1, 1'b0);
      expectBit("b2b_ready0", in_ready0, 1'b1);
      expectBit("b2b_ready1", in_ready1, 1'b1);
      applyStimulus(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      expectBit("b2b_nobubble0", out_valid0, 1'b1);
      expectBit("b2b_nobubble1", out_valid1, 1'b1);
      drain();

      // Stall: first beat must hold for three cycles, and new requests are ignored.
      applyStimulus(1'b1, 8'hFF, 4'h4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'h0F, 4'hE, 1'b0, 1'b0);
         expectBit("stall_ready0", in_ready0, 1'b0);
      end
      drain();

      // Flush on the second beat, then a fresh request.
      applyStimulus(1'b1, 8'hFF, 4'h6, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      expectBit("flush_idle0", out_valid0, 1'b0);
      expectBit("flush_idle1", out_valid1, 1'b0);
      applyStimulus(1'b1, 8'h24, 4'h8, 1'b1, 1'b0);
      expectBit("post_flush_ready0", in_ready0, 1'b1);
      drain();

      // Flush while idle blocks acceptance.
      applyStimulus(1'b1, 8'h3C, 4'hA, 1'b1, 1'b1);
      expectBit("flush_gates_ready0", in_ready0, 1'b0);
      applyStimulus(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      expectBit("flush_no_accept0", out_valid0, 1'b0);

      // Asynchronous reset between clock edges during a scan.
      applyStimulus(1'b1, 8'hFF, 4'h5, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      expectBit("async_valid0", out_valid0, 1'b0);
      expectBit("async_ready0", in_ready0, 1'b1);
      expectBit("async_valid1", out_valid1, 1'b0);
      checks++;
      if ({vld0, last0, tag0, out_idx0} !== '0) begin
         errors++;
         $display("[TB] FAIL async_outputs got=%h required=0", {vld0, last0, tag0, out_idx0});
      end
      q0.delete();
      q1.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 8'h81, 4'h2, 1'b1, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wired_bitscan_iter.md
Name: wired_bitscan_iter

Overview:
- Parametrised, sequential successor to the combinational find-first-set counter.
- Accepts one WIDTH-bit mask per request and emits the indices of all set bits over one or more output beats, up to LANES indices per beat.
- Scan order is LSB-first or MSB-first.
- Used for multi-register free lists, store-multiple sequencing, and way/entry iteration in the backend.

Parameters:
- WIDTH, 16, mask width in bits (>=2).
- LANES, 2, maximum indices emitted per beat (1..WIDTH).
- MODE, 1'b0, 0 = LSB-first (ascending index), 1 = MSB-first (descending index).
- TAG_W, 4, width of the opaque request tag carried to every beat.
- IDX_W, $clog2(WIDTH), dependent; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort of the current scan.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i & in_ready_o.
- in_mask_i  in  WIDTH  bits to iterate.
- in_tag_i  in  TAG_W  request tag.
- out_valid_o  out  1  beat valid.
- out_ready_i  in  1  beat consumed when out_valid_o & out_ready_i.
- out_idx_o  out  LANES*IDX_W  lane k index, lane 0 = first in scan order.
- out_lane_vld_o  out  LANES  per-lane valid, always a contiguous prefix (thermometer).
- out_last_o  out  1  final beat of this request.
- out_tag_o  out  TAG_W  tag of the request in progress.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset state: state=IDLE, rem_q=0, tag_q=0.
  - Output reset values: out_valid_o=0, in_ready_o=1, out_lane_vld_o=0, out_last_o=0, out_idx_o=0, out_tag_o=0.
- FSM states:
  - IDLE: in_ready_o=1, out_valid_o=0. On accept: rem_q<=in_mask_i, tag_q<=in_tag_i, go to SCAN.
  - SCAN: out_valid_o=1. Beat contents are combinational from rem_q.
    - Lane 0 = first set bit of rem_q in MODE order.
    - Lane k = first set bit after clearing the lanes 0..k-1 bits.
    - out_lane_vld_o[k] = that lane found a bit.
    - Lanes without a valid bit drive index 0.
- Last beat: out_last_o = 1 when rem_q with all emitted lane bits cleared equals 0.
- On out handshake:
  - Not last: rem_q <= rem_q & ~emitted bits.
  - Last: rem_q <= 0 and go to IDLE.
- Back-to-back: in_ready_o is also 1 in SCAN when out_valid_o & out_ready_i & out_last_o.
  - A request accepted in that cycle loads directly and stays in SCAN, giving no bubble.
- Zero mask: produces exactly one beat with out_lane_vld_o=0 and out_last_o=1, so every request gets exactly one last beat.
- Latency: the first beat is visible the cycle after acceptance. Throughput is one beat per cycle while out_ready_i=1.
- Beats per request: ceil(popcount/LANES), minimum 1.
- Stall: while out_valid_o & ~out_ready_i, all outputs hold stable (AXI-style); in_valid_i and in_mask_i are ignored.
- flush_i:
  - Forces state=IDLE and rem_q=0 next cycle, overriding any handshake in the same cycle.
  - No input is accepted in a flush cycle: in_ready_o is gated low by flush_i.
- Reset mid-scan: outputs return to reset values immediately (asynchronous); the partial request is discarded.
- WIDTH not a power of two: index tree pads to 2**IDX_W, and pad bits are treated as 0.
- LANES >= popcount: the whole request completes in one beat.

Optional Feature:
- Macro: WIRED_BITSCAN_POPCNT_EN.
- When defined:
  - Adds output out_remain_o of width $clog2(WIDTH+1): popcount of rem_q (bits still to emit, including the current beat).
  - Adds output out_first_o: high on the first beat of each request.
  - Adds a registered first-beat flag, set on accept and cleared on out handshake.
- When undefined: neither port exists and no popcount logic is synthesised. Core behaviour is identical.

Decomposition:
- Package wired_bitscan_pkg holds:
  - typedef scan_state_e {IDLE, SCAN}.
  - Function bitrev(mask) for MODE=1 (reverses the mask once at load; indices re-mapped as WIDTH-1-i at output).
  - localparam helper for the popcount width.
- Sub-module wired_bitscan_lane:
  - Combinational: input mask, output found, idx, cleared_mask.
  - Balanced binary find-first tree.
  - Instantiated LANES times in a cascade.

Test Plan:
- WIDTH=8, LANES=2, MODE=0, mask=8'b1011_0010, out_ready=1 -> beat0 idx{1,4} vld=11 last=0; beat1 idx{5,7} vld=11 last=1; then IDLE.
- Same mask, MODE=1 -> beat0 idx{7,5} last=0; beat1 idx{4,1} last=1.
- mask=0, tag=3 -> single beat, vld=00, last=1, tag=3, one cycle after accept.
- mask=8'b0000_0100 followed immediately by mask=8'b1000_0000 -> beat idx{2} vld=01 last=1, with in_ready=1 in the same cycle; next cycle beat idx{7} last=1 with no bubble.
- mask=8'hFF, out_ready held 0 for 3 cycles after the first beat -> outputs stable idx{0,1}; then 4 beats total, last on idx{6,7}.
- mask=8'hFF, flush_i on the second beat cycle with out_ready=1 -> next cycle IDLE, out_valid=0; a new request is accepted the following cycle.
- Assert rst_n low during SCAN -> out_valid_o=0 and in_ready_o=1 immediately, without waiting for a clock edge.
